// File: rtl/fa_exhaustive_checker_pkg.sv
// Shared types and constants for the exhaustive full-adder checker.
// Maps a vector index onto the adder inputs.
package fa_chk_pkg;

  localparam int unsigned NumVec = 8;
  localparam int unsigned IdxW   = 3;
  localparam int unsigned ErrW   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  // Returns {A, B, Cin}; idx bits are {Cin, A, B}, so Cin toggles slowest.
  function automatic logic [2:0] vec_of(input logic [IdxW-1:0] idx);
    return {idx[1], idx[0], idx[2]};
  endfunction

endpackage

// File: rtl/fa_exhaustive_checker_if.sv
// Connection between the checker and the 1-bit full adder under test.
// The checker drives the adder inputs and observes its outputs.
interface fa_exhaustive_checker_if;

  logic A;
  logic B;
  logic Cin;
  logic S;
  logic Cout;

  modport master (output A, B, Cin, input S, Cout);
  modport slave  (input A, B, Cin, output S, Cout);

endinterface

// File: rtl/fa_exhaustive_checker_golden_model.sv
// Reference 1-bit full adder.
// Used to produce the expected response for each applied vector.
module fa_golden_model (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s_exp,
  output logic cout_exp
);

  assign s_exp    = a ^ b ^ cin;
  assign cout_exp = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_exhaustive_checker.sv
// Applies all 8 input vectors to a full adder, holds each for HoldCycles clocks,
// and compares the sampled response against the golden model.
module fa_exhaustive_checker
  import fa_chk_pkg::*;
#(
  parameter int unsigned HoldCycles = 3
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  fa_exhaustive_checker_if.master aut,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ErrW-1:0]        err_cnt,
  output logic [IdxW-1:0]        fail_vec,
  output logic                   fail_valid
);

  localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]      vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ErrW-1:0] err_q, err_d;
  logic [IdxW-1:0] fail_vec_q, fail_vec_d;
  logic            fail_valid_q, fail_valid_d;

  logic s_exp, cout_exp, mismatch;

  // Expected response is derived from the registered stimulus, not from idx.
  fa_golden_model u_golden (
    .a        (vec_q[2]),
    .b        (vec_q[1]),
    .cin      (vec_q[0]),
    .s_exp    (s_exp),
    .cout_exp (cout_exp)
  );

  assign mismatch = (aut.S != s_exp) | (aut.Cout != cout_exp);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StDrive;
          idx_d        = '0;
          hold_d       = '0;
          vec_d        = vec_of('0);
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_vec_d   = '0;
          fail_valid_d = 1'b0;
        end
      end
      StDrive: begin
        if (hold_q != HoldLast) begin
          hold_d = hold_q + HoldW'(1);
        end else begin
          hold_d = '0;
          if (mismatch) begin
            err_d = err_q + ErrW'(1);
            if (!fail_valid_q) begin
              fail_vec_d   = idx_q;
              fail_valid_d = 1'b1;
            end
          end
          if (idx_q == IdxW'(NumVec - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + IdxW'(1);
            vec_d = vec_of(idx_q + IdxW'(1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      hold_q       <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign {aut.A, aut.B, aut.Cin} = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Directed bench for the full-adder checker: two instances (hold 3 and hold 1)
// driving a bench-side adder model with selectable faults.
module tb_fa_exhaustive_checker;

  logic clk = 1'b0;
  logic n_rst;
  logic start3, start1;
  int   fault;  // 0: correct, 1: S stuck-at-0, 2: Cout inverted

  logic       busy3, done3, pass3, fvalid3;
  logic [3:0] err3;
  logic [2:0] fvec3;
  logic       busy1, done1, pass1, fvalid1;
  logic [3:0] err1;
  logic [2:0] fvec1;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_order [8];
  logic [2:0] sb_q [$];

  always #5 clk = ~clk;

  fa_exhaustive_checker_if if3 ();
  fa_exhaustive_checker_if if1 ();

  assign if3.S    = (fault == 1) ? 1'b0 : (if3.A ^ if3.B ^ if3.Cin);
  assign if3.Cout = ((if3.A & if3.B) | (if3.A & if3.Cin) | (if3.B & if3.Cin)) ^ (fault == 2);
  assign if1.S    = (fault == 1) ? 1'b0 : (if1.A ^ if1.B ^ if1.Cin);
  assign if1.Cout = ((if1.A & if1.B) | (if1.A & if1.Cin) | (if1.B & if1.Cin)) ^ (fault == 2);

  fa_exhaustive_checker #(.HoldCycles(3)) dut3 (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start3),
    .aut        (if3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_cnt    (err3),
    .fail_vec   (fvec3),
    .fail_valid (fvalid3)
  );

  fa_exhaustive_checker #(.HoldCycles(1)) dut1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start1),
    .aut        (if1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err1),
    .fail_vec   (fvec1),
    .fail_valid (fvalid1)
  );

  // {busy, done, pass, err_cnt, fail_vec, fail_valid, A, B, Cin}
  logic [13:0] st3, st1;
  assign st3 = {busy3, done3, pass3, err3, fvec3, fvalid3, if3.A, if3.B, if3.Cin};
  assign st1 = {busy1, done1, pass1, err1, fvec1, fvalid1, if1.A, if1.B, if1.Cin};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v;
    else start3 = v;
  endtask

  // One full run on the selected instance; optionally re-pulse start mid-run.
  task automatic run(input int sel, input bit repulse, input string name);
    int h;
    int err_e;
    int first_e;
    logic [13:0] st;
    logic [2:0] v;
    logic a, b, c, s_t, co_t, s_f, co_f;
    h = (sel == 1) ? 1 : 3;
    err_e = 0;
    first_e = 0;
    for (int k = 0; k < 8; k++) begin
      v = exp_order[k];
      sb_q.push_back(v);
      {a, b, c} = v;
      s_t  = a ^ b ^ c;
      co_t = (a & b) | (a & c) | (b & c);
      s_f  = (fault == 1) ? 1'b0 : s_t;
      co_f = (fault == 2) ? ~co_t : co_t;
      if ((s_f != s_t) || (co_f != co_t)) begin
        if (err_e == 0) first_e = k;
        err_e++;
      end
    end
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    for (int cyc = 0; cyc < 8 * h; cyc++) begin
      st = (sel == 1) ? st1 : st3;
      if (cyc % h == 0) begin
        v = sb_q.pop_front();
        chk({name, ".vec"}, {13'b0, st[2:0]}, {13'b0, v});
        chk({name, ".busy_done"}, {14'b0, st[13:12]}, 16'h2);
        if (cyc == 0) begin
          chk({name, ".cleared"}, {8'b0, st[10:3]}, 16'h0);
        end
      end
      if (repulse && cyc == 4) set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
    end
    st = (sel == 1) ? st1 : st3;
    chk({name, ".busy_done"}, {14'b0, st[13:12]}, 16'h1);
    chk({name, ".pass"}, {15'b0, st[11]}, {15'b0, err_e == 0});
    chk({name, ".err_cnt"}, {12'b0, st[10:7]}, 16'(err_e));
    chk({name, ".fail_vec"}, {13'b0, st[6:4]}, 16'(first_e));
    chk({name, ".fail_valid"}, {15'b0, st[3]}, {15'b0, err_e != 0});
    chk({name, ".vec_held"}, {13'b0, st[2:0]}, 16'h7);
    chk({name, ".sb_empty"}, 16'(sb_q.size()), 16'h0);
  endtask

  initial begin
    exp_order = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    fault  = 0;
    n_rst  = 1'b0;
    start3 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset3", {2'b0, st3}, 16'h0);
    chk("reset1", {2'b0, st1}, 16'h0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle3", {2'b0, st3}, 16'h0);

    run(0, 1'b0, "good_h3");
    fault = 1;
    run(0, 1'b0, "s_stuck0");
    fault = 2;
    run(0, 1'b0, "cout_inv");
    fault = 0;
    run(0, 1'b1, "restart_repulse");

    // Reset mid-run at cycle 10, then reset wins over start.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrun_busy", {15'b0, busy3}, 16'h1);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_reset", {2'b0, st3}, 16'h0);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_wins", {2'b0, st3}, 16'h0);
    n_rst  = 1'b1;
    start3 = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst", {2'b0, st3}, 16'h0);

    run(1, 1'b0, "good_h1");
    fault = 1;
    run(1, 1'b0, "s_stuck0_h1");
    fault = 0;
    run(0, 1'b0, "good_h3_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
